sram_ctrl_param: RTL and testbench

Parametrised single-port asynchronous SRAM controller. It succeeds the fixed 16-bit/18-bit opcode-driven controller.
- Accepts read/write requests over a valid/ready handshake.
- Generates registered, glitch-free SRAM strobes with a programmable number of access wait cycles.
- Supports per-byte write enables and a split tristate data bus (o/i/oe) for the top-level pad.
- Sits between the memory-stage request logic and the external SRAM pins.

---
 rtl/sram_ctrl_pkg.sv | 21 ++
 rtl/sram_wait_cnt.sv | 31 +++
 rtl/sram_ctrl_param.sv | 106 ++++++++++
 tb/tb_sram_ctrl_param.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the parametrised SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ACC   = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_ACC   = 3'd3,
    ST_WR_HOLD  = 3'd4
  } sram_state_t;

  localparam int SRAM_ADDR_W   = 18;
  localparam int SRAM_DATA_W   = 16;
  localparam int SRAM_WAIT_CYC = 3;

  // Wide enough to hold WAIT_CYC-1 and never collapse to zero bits.
  function automatic int cnt_width(input int wait_cyc);
    return (wait_cyc < 1) ? 1 : $clog2(wait_cyc + 1);
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter that times the active strobe window of an access.
module sram_wait_cnt
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYC = SRAM_WAIT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int CNT_W = cnt_width(WAIT_CYC);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sram_ctrl_param.sv
// Single-port asynchronous SRAM controller: valid/ready requests in,
// registered strobes and split tristate data bus out.
module sram_ctrl_param
  import sram_ctrl_pkg::*;
#(
  parameter  int ADDR_W   = SRAM_ADDR_W,
  parameter  int DATA_W   = SRAM_DATA_W,
  parameter  int WAIT_CYC = SRAM_WAIT_CYC,
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_dq_oe,
  output logic [BE_W-1:0]   sram_be_n,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  sram_state_t r_state;
  sram_state_t w_next;
  logic        w_accept;
  logic        w_cnt_zero;
  logic        w_cnt_load;
  logic        w_cnt_dec;

  assign req_ready = (r_state == ST_IDLE) && rst;
  assign w_accept  = req_valid && req_ready;

  assign w_cnt_load = (w_accept && !req_we) || (r_state == ST_WR_SETUP);
  assign w_cnt_dec  = (r_state == ST_RD_ACC) || (r_state == ST_WR_ACC);

  sram_wait_cnt #(
    .WAIT_CYC(WAIT_CYC)
  ) u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_cnt_load),
    .i_dec  (w_cnt_dec),
    .o_zero (w_cnt_zero)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_accept) w_next = req_we ? ST_WR_SETUP : ST_RD_ACC;
      ST_RD_ACC:   if (w_cnt_zero) w_next = ST_IDLE;
      ST_WR_SETUP: w_next = ST_WR_ACC;
      ST_WR_ACC:   if (w_cnt_zero) w_next = ST_WR_HOLD;
      ST_WR_HOLD:  w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Pin flops are decoded from the next state so strobes line up with the
  // state they belong to while still coming straight out of registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= '1;
      sram_dq_oe <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      r_state  <= w_next;
      rd_valid <= 1'b0;
      if (w_accept) begin
        sram_addr <= req_addr;
        sram_dq_o <= req_wdata;
        sram_be_n <= req_we ? ~req_be : '0;
      end else if (w_next == ST_IDLE) begin
        sram_be_n <= '1;
      end
      if ((r_state == ST_RD_ACC) && w_cnt_zero) begin
        rd_valid <= 1'b1;
        rd_data  <= sram_dq_i;
      end
      sram_ce_n  <= (w_next == ST_IDLE);
      sram_oe_n  <= (w_next != ST_RD_ACC);
      sram_we_n  <= (w_next != ST_WR_ACC);
      sram_dq_oe <= (w_next == ST_WR_SETUP) || (w_next == ST_WR_ACC) ||
                    (w_next == ST_WR_HOLD);
    end
  end

  // The pad must never drive while the SRAM is driving back.
  a_oe_excl: assert property (@(posedge clk) disable iff (!rst)
                              !(!sram_oe_n && sram_dq_oe));

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Directed bench for sram_ctrl_param with a scoreboard of expected reads,
// exercising a 16-bit/WAIT_CYC=2 instance and a 32-bit/WAIT_CYC=4 instance.
module tb_sram_ctrl_param;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   excl = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rq0_valid, rq0_we, rdy0, rdv0, oe0, ce0, oen0, wen0;
  logic [17:0] rq0_addr, a0;
  logic [15:0] rq0_wdata, rdd0, dqo0, dqi0;
  logic [1:0]  rq0_be, ben0;

  logic        rq1_valid, rq1_we, rdy1, rdv1, oe1, ce1, oen1, wen1;
  logic [19:0] rq1_addr, a1;
  logic [31:0] rq1_wdata, rdd1, dqo1, dqi1;
  logic [3:0]  rq1_be, ben1;

  sram_ctrl_param #(.ADDR_W(18), .DATA_W(16), .WAIT_CYC(2)) u0 (
    .clk(clk), .rst(rst_n), .req_valid(rq0_valid), .req_ready(rdy0), .req_we(rq0_we),
    .req_addr(rq0_addr), .req_wdata(rq0_wdata), .req_be(rq0_be), .rd_valid(rdv0),
    .rd_data(rdd0), .sram_addr(a0), .sram_dq_o(dqo0), .sram_dq_i(dqi0), .sram_dq_oe(oe0),
    .sram_be_n(ben0), .sram_ce_n(ce0), .sram_oe_n(oen0), .sram_we_n(wen0));

  sram_ctrl_param #(.ADDR_W(20), .DATA_W(32), .WAIT_CYC(4)) u1 (
    .clk(clk), .rst(rst_n), .req_valid(rq1_valid), .req_ready(rdy1), .req_we(rq1_we),
    .req_addr(rq1_addr), .req_wdata(rq1_wdata), .req_be(rq1_be), .rd_valid(rdv1),
    .rd_data(rdd1), .sram_addr(a1), .sram_dq_o(dqo1), .sram_dq_i(dqi1), .sram_dq_oe(oe1),
    .sram_be_n(ben1), .sram_ce_n(ce1), .sram_oe_n(oen1), .sram_we_n(wen1));

  logic [15:0] mem0 [0:1023];
  logic [15:0] ref0 [0:1023];
  logic [31:0] mem1 [0:15];
  logic [31:0] ref1 [0:15];

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Asynchronous SRAM models: write on the rising edge of WE_N, read while OE_N low.
  always @(posedge wen0) if (rst_n && !ce0)
    mem0[a0[9:0]] <= 16'(merge({16'h0, mem0[a0[9:0]]}, {16'h0, dqo0}, {2'b00, ~ben0}));
  always @(posedge wen1) if (rst_n && !ce1)
    mem1[a1[3:0]] <= merge(mem1[a1[3:0]], dqo1, ~ben1);
  assign dqi0 = (!ce0 && !oen0) ? mem0[a0[9:0]] : 16'h0;
  assign dqi1 = (!ce1 && !oen1) ? mem1[a1[3:0]] : 32'h0;

  // Scoreboard push at each accept edge.
  always @(posedge clk) begin
    if (rq0_valid && rdy0) begin
      if (rq0_we)
        ref0[rq0_addr[9:0]] <= 16'(merge({16'h0, ref0[rq0_addr[9:0]]}, {16'h0, rq0_wdata},
                                         {2'b00, rq0_be}));
      else q0.push_back('{{16'h0, ref0[rq0_addr[9:0]]}, cyc + 1 + 2});
    end
    if (rq1_valid && rdy1) begin
      if (rq1_we) ref1[rq1_addr[3:0]] <= merge(ref1[rq1_addr[3:0]], rq1_wdata, rq1_be);
      else q1.push_back('{ref1[rq1_addr[3:0]], cyc + 1 + 4});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!oen0 && oe0) excl++;
    if (!oen1 && oe1) excl++;
    if (rdv0) begin
      if (q0.size() == 0) chk("rd_unexpected0", 64'(q0.size()), 64'd1);
      else begin
        e = q0.pop_front();
        chk("rd_data0", {48'h0, rdd0}, {32'h0, e.d});
        chk("rd_latency0", 64'(cyc), 64'(e.due));
      end
    end
    if (rdv1) begin
      if (q1.size() == 0) chk("rd_unexpected1", 64'(q1.size()), 64'd1);
      else begin
        e = q1.pop_front();
        chk("rd_data1", {32'h0, rdd1}, {32'h0, e.d});
        chk("rd_latency1", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic drive(input int u, input logic we, input logic [19:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic keep, output int acc);
    int k;
    k = 0;
    @(negedge clk);
    if (u == 0) begin
      rq0_we = we; rq0_addr = a[17:0]; rq0_wdata = d[15:0]; rq0_be = be[1:0]; rq0_valid = 1'b1;
    end else begin
      rq1_we = we; rq1_addr = a; rq1_wdata = d; rq1_be = be; rq1_valid = 1'b1;
    end
    while (!((u == 0) ? rdy0 : rdy1) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("accept_timeout", 64'(k < 50), 64'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    if (!keep) begin
      rq0_valid = 1'b0;
      rq1_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("drain_timeout", 64'(k < 100), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rel, wl, oeh, dqbad;
    int t[4];
    rst_n = 1'b0;
    rq0_valid = 1'b0; rq0_we = 1'b0; rq0_addr = '0; rq0_wdata = '0; rq0_be = '1;
    rq1_valid = 1'b0; rq1_we = 1'b0; rq1_addr = '0; rq1_wdata = '0; rq1_be = '1;
    for (int i = 0; i < 1024; i++) begin mem0[i] = '0; ref0[i] = '0; end
    for (int i = 0; i < 4; i++) begin mem0[i] = 16'(16'hA0 + i); ref0[i] = 16'(16'hA0 + i); end
    for (int i = 0; i < 16; i++) begin mem1[i] = '0; ref1[i] = '0; end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce_n", 64'(ce0), 64'd1);
    chk("rst_oe_n", 64'(oen0), 64'd1);
    chk("rst_we_n", 64'(wen0), 64'd1);
    chk("rst_be_n", 64'(ben0), 64'h3);
    chk("rst_dq_oe", 64'(oe0), 64'd0);
    chk("rst_ready", 64'(rdy0), 64'd0);
    chk("rst_rd_valid", 64'(rdv0), 64'd0);
    chk("rst_addr", 64'(a0), 64'd0);
    chk("rst_rd_data", 64'(rdd0), 64'd0);
    chk("rst_be_n1", 64'(ben1), 64'hF);
    #2 rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 64'(rdy0), 64'd1);

    // Full write, then read it back.
    drive(0, 1'b1, 20'h00123, 32'hBEEF, 4'b0011, 1'b0, acc);
    wl = 0; oeh = 0; dqbad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!wen0) wl++;
      if (oe0) begin
        oeh++;
        if (dqo0 !== 16'hBEEF) dqbad++;
      end
      if (i == 0) begin
        chk("wr_addr", 64'(a0), 64'h123);
        chk("wr_be_n_full", 64'(ben0), 64'h0);
      end
    end
    chk("we_n_low_cycles", 64'(wl), 64'd2);
    chk("dq_oe_cycles", 64'(oeh), 64'd4);
    chk("dq_o_value", 64'(dqbad), 64'd0);
    drive(0, 1'b0, 20'h00123, 32'h0, 4'b0011, 1'b0, acc);
    drain();
    chk("rd_beef", 64'(rdd0), 64'hBEEF);

    // Byte-lane write.
    drive(0, 1'b1, 20'h00123, 32'h1234, 4'b0001, 1'b0, acc);
    @(negedge clk);
    chk("wr_be_n_byte", 64'(ben0), 64'h2);
    drive(0, 1'b0, 20'h00123, 32'h0, 4'b0011, 1'b0, acc);
    drain();
    chk("rd_be34", 64'(rdd0), 64'hBE34);

    // Back-to-back reads with req_valid held high.
    for (int i = 0; i < 4; i++) drive(0, 1'b0, 20'(i), 32'h0, 4'b0011, 1'(i < 3), t[i]);
    for (int i = 1; i < 4; i++) chk("read_spacing", 64'(t[i] - t[i-1]), 64'd3);
    drain();
    chk("rd_last_burst", 64'(rdd0), 64'hA3);

    // Reset during the second WR_ACC cycle.
    drive(0, 1'b1, 20'h00200, 32'h5555, 4'b0011, 1'b0, acc);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("in_wr_acc", 64'(wen0), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_we_n", 64'(wen0), 64'd1);
    chk("abort_dq_oe", 64'(oe0), 64'd0);
    chk("abort_ce_n", 64'(ce0), 64'd1);
    chk("abort_ready", 64'(rdy0), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel = cyc;
    rq0_we = 1'b0; rq0_addr = 18'h1; rq0_be = 2'b11; rq0_valid = 1'b1;
    @(posedge clk);
    #1;
    rq0_valid = 1'b0;
    chk("accept_after_rst", 64'(cyc - rel), 64'd1);
    chk("read_started", 64'(oen0), 64'd0);
    drain();

    // 32-bit instance, WAIT_CYC = 4.
    drive(1, 1'b1, 20'h00000, 32'hDEADBEEF, 4'b0110, 1'b0, acc);
    @(negedge clk);
    chk("wr_be_n_32", 64'(ben1), 64'h9);
    drive(1, 1'b0, 20'h00000, 32'h0, 4'b1111, 1'b0, acc);
    drain();
    chk("rd_32", 64'(rdd1), 64'h00ADBE00);

    chk("oe_dq_oe_exclusive", 64'(excl), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
